// File: rtl/snn_pkg.sv
// Shared defaults, FSM encoding and saturating-add helper for the SNN hidden-layer datapath.
package snn_pkg;

  localparam int SNN_VW         = 16;
  localparam int SNN_WW         = 8;
  localparam int SNN_N_NEURON   = 40;
  localparam int SNN_THRESH     = 128;
  localparam int SNN_LEAK_SHIFT = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INIT  = 2'd1,
    S_ACCUM = 2'd2,
    S_REUSE = 2'd3
  } state_t;

  // Clamp a one-bit-wider sum back to SNN_VW signed bits.
  function automatic logic signed [SNN_VW-1:0] sat(input logic signed [SNN_VW:0] s);
    if (s[SNN_VW] != s[SNN_VW-1])
      return s[SNN_VW] ? {1'b1, {(SNN_VW-1){1'b0}}} : {1'b0, {(SNN_VW-1){1'b1}}};
    return s[SNN_VW-1:0];
  endfunction

endpackage

// File: rtl/lif_fire_unit.sv
// Combinational LIF update: saturating add of voltage and current, threshold compare,
// subtractive reset on fire.
module lif_fire_unit
  import snn_pkg::*;
#(
  parameter int                   VW     = SNN_VW,
  parameter logic signed [VW-1:0] THRESH = VW'(SNN_THRESH)
) (
  input  logic signed [VW-1:0] acc,
  input  logic signed [VW-1:0] cur,
  output logic                 fire,
  output logic signed [VW-1:0] v_new
);

  logic signed [VW-1:0] v;

  always_comb begin
    v     = sat({acc[VW-1], acc} + {cur[VW-1], cur});
    fire  = (v >= THRESH);
    // v >= THRESH >= 0 here, so the subtraction cannot wrap.
    v_new = fire ? v - THRESH : v;
  end

endmodule

// File: rtl/hidden_neuron_acc.sv
// Hidden-layer LIF neuron accumulator: voltage/current memories, accumulation FSM and spike output.
// Optional input leak at load time is enabled by defining HNA_LEAK_EN.
module hidden_neuron_acc
  import snn_pkg::*;
#(
  parameter int                   N_NEURON   = SNN_N_NEURON,
  parameter int                   VW         = SNN_VW,
  parameter int                   WW         = SNN_WW,
`ifdef HNA_LEAK_EN
  parameter int                   LEAK_SHIFT = SNN_LEAK_SHIFT,
`endif
  parameter logic signed [VW-1:0] THRESH     = VW'(SNN_THRESH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vol_mem_control,
  input  logic signed [VW-1:0] init_mem_vol,
  input  logic                 load_voltage,
  input  logic                 arithm,
  input  logic                 w_n_a_valid,
  input  logic signed [WW-1:0] weight,
  input  logic                 act,
  input  logic                 export_voltage,
  output logic                 spike_valid,
  output logic                 spike_out,
  output logic [5:0]           spike_idx,
  output logic signed [VW-1:0] vol_out,
  output logic                 proto_err
);

  state_t               state_q, state_d;
  logic [5:0]           ptr_q, ptr_d, ptr_next;
  logic signed [VW-1:0] acc_q, acc_d;
  logic signed [VW-1:0] cur_acc_q, cur_acc_d;
  logic                 spike_valid_q, spike_valid_d;
  logic                 spike_out_q, spike_out_d;
  logic [5:0]           spike_idx_q, spike_idx_d;
  logic signed [VW-1:0] vol_out_q, vol_out_d;
  logic                 proto_err_q, proto_err_d;

  logic signed [VW-1:0] vol_mem [N_NEURON];
  logic signed [VW-1:0] cur_mem [N_NEURON];
  logic                 vol_we, cur_we;
  logic signed [VW-1:0] vol_wdata, cur_wdata;
  logic signed [VW-1:0] vol_rd, vol_load;
  logic signed [VW:0]   cur_sum;
  logic                 fire;
  logic signed [VW-1:0] fire_v;

  lif_fire_unit #(
    .VW     (VW),
    .THRESH (THRESH)
  ) u_fire (
    .acc   (acc_q),
    .cur   (cur_acc_q),
    .fire  (fire),
    .v_new (fire_v)
  );

  always_comb begin
    vol_rd   = vol_mem[ptr_q];
`ifdef HNA_LEAK_EN
    vol_load = vol_rd - (vol_rd >>> LEAK_SHIFT);
`else
    vol_load = vol_rd;
`endif
    cur_sum  = {cur_acc_q[VW-1], cur_acc_q} + {{(VW+1-WW){weight[WW-1]}}, weight};
    ptr_next = (ptr_q == 6'(N_NEURON-1)) ? '0 : ptr_q + 6'd1;
  end

  // Priority chain: init strobe, then export, then load, then weight beat.
  always_comb begin
    state_d       = (state_q == S_INIT) ? S_IDLE : state_q;
    ptr_d         = ptr_q;
    acc_d         = acc_q;
    cur_acc_d     = cur_acc_q;
    spike_valid_d = 1'b0;
    spike_out_d   = spike_out_q;
    spike_idx_d   = spike_idx_q;
    vol_out_d     = vol_out_q;
    proto_err_d   = proto_err_q;
    vol_we        = 1'b0;
    cur_we        = 1'b0;
    vol_wdata     = fire_v;
    cur_wdata     = cur_acc_q;

    if (vol_mem_control) begin
      vol_we    = 1'b1;
      cur_we    = 1'b1;
      vol_wdata = init_mem_vol;
      cur_wdata = '0;
      ptr_d     = ptr_next;
      state_d   = S_INIT;
    end else if (export_voltage) begin
      if (load_voltage) proto_err_d = 1'b1;
      if (state_q == S_ACCUM || state_q == S_REUSE) begin
        vol_we        = 1'b1;
        cur_we        = (state_q == S_ACCUM);
        spike_valid_d = 1'b1;
        spike_out_d   = fire;
        spike_idx_d   = ptr_q;
        vol_out_d     = fire_v;
        ptr_d         = ptr_next;
        state_d       = S_IDLE;
      end else begin
        proto_err_d = 1'b1;
      end
    end else if (load_voltage) begin
      if (state_q == S_IDLE) begin
        acc_d     = vol_load;
        cur_acc_d = arithm ? cur_mem[ptr_q] : '0;
        state_d   = arithm ? S_REUSE : S_ACCUM;
      end else begin
        proto_err_d = 1'b1;
      end
    end else if (w_n_a_valid && act && state_q == S_ACCUM) begin
      cur_acc_d = sat(cur_sum);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      acc_q         <= '0;
      cur_acc_q     <= '0;
      spike_valid_q <= 1'b0;
      spike_out_q   <= 1'b0;
      spike_idx_q   <= '0;
      vol_out_q     <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      acc_q         <= acc_d;
      cur_acc_q     <= cur_acc_d;
      spike_valid_q <= spike_valid_d;
      spike_out_q   <= spike_out_d;
      spike_idx_q   <= spike_idx_d;
      vol_out_q     <= vol_out_d;
      proto_err_q   <= proto_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (vol_we) vol_mem[ptr_q] <= vol_wdata;
    if (cur_we) cur_mem[ptr_q] <= cur_wdata;
  end

  assign spike_valid = spike_valid_q;
  assign spike_out   = spike_out_q;
  assign spike_idx   = spike_idx_q;
  assign vol_out     = vol_out_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_hidden_neuron_acc.sv
// Directed self-checking bench for hidden_neuron_acc (default build, no leak).
module tb_hidden_neuron_acc;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               vol_mem_control;
  logic signed [15:0] init_mem_vol;
  logic               load_voltage;
  logic               arithm;
  logic               w_n_a_valid;
  logic signed [7:0]  weight;
  logic               act;
  logic               export_voltage;
  logic               spike_valid;
  logic               spike_out;
  logic [5:0]         spike_idx;
  logic signed [15:0] vol_out;
  logic               proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hidden_neuron_acc dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .vol_mem_control (vol_mem_control),
    .init_mem_vol    (init_mem_vol),
    .load_voltage    (load_voltage),
    .arithm          (arithm),
    .w_n_a_valid     (w_n_a_valid),
    .weight          (weight),
    .act             (act),
    .export_voltage  (export_voltage),
    .spike_valid     (spike_valid),
    .spike_out       (spike_out),
    .spike_idx       (spike_idx),
    .vol_out         (vol_out),
    .proto_err       (proto_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input logic signed [15:0] val);
    vol_mem_control = 1'b1;
    init_mem_vol    = val;
    repeat (40) step();
    vol_mem_control = 1'b0;
    step();
  endtask

  task automatic load(input logic ar);
    load_voltage = 1'b1;
    arithm       = ar;
    step();
    load_voltage = 1'b0;
    arithm       = 1'b0;
  endtask

  task automatic beat(input logic signed [7:0] w, input logic a);
    w_n_a_valid = 1'b1;
    weight      = w;
    act         = a;
    step();
    w_n_a_valid = 1'b0;
    act         = 1'b0;
  endtask

  task automatic do_export();
    export_voltage = 1'b1;
    step();
    export_voltage = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vol_mem_control = 0; init_mem_vol = 0; load_voltage = 0; arithm = 0;
    w_n_a_valid = 0; weight = 0; act = 0; export_voltage = 0;
    step(); step();
    checks++;
    if ({spike_valid, spike_out, spike_idx, vol_out, proto_err} !== 25'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b s=%b i=%0d vol=%0d pe=%b want all 0",
               spike_valid, spike_out, spike_idx, vol_out, proto_err);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_init_sweep();
    sweep(16'sd63);
    load(1'b0);
    do_export();
    checks++;
    if ({spike_valid, spike_out, spike_idx, vol_out} !== {1'b1, 1'b0, 6'd0, 16'sd63}) begin
      errors++;
      $display("FAIL init_export got v=%b s=%b i=%0d vol=%0d want v=1 s=0 i=0 vol=63",
               spike_valid, spike_out, spike_idx, vol_out);
    end
    step();
    checks++;
    if (spike_valid !== 1'b0) begin
      errors++;
      $display("FAIL spike_pulse_width got %b want 0", spike_valid);
    end
  endtask

  task automatic test_accum_fire();
    for (int i = 1; i < 40; i++) begin
      load(1'b0);
      do_export();
      checks++;
      if ({spike_valid, spike_out, spike_idx, vol_out} !== {1'b1, 1'b0, 6'(i), 16'sd63}) begin
        errors++;
        $display("FAIL walk_step0 got v=%b s=%b i=%0d vol=%0d want v=1 s=0 i=%0d vol=63",
                 spike_valid, spike_out, spike_idx, vol_out, i);
      end
    end
    load(1'b0);
    beat(8'sd40, 1'b1);
    beat(8'sd30, 1'b1);
    beat(8'sd100, 1'b0);
    do_export();
    checks++;
    if ({spike_valid, spike_out, spike_idx, vol_out} !== {1'b1, 1'b1, 6'd0, 16'sd5}) begin
      errors++;
      $display("FAIL accum_fire got v=%b s=%b i=%0d vol=%0d want v=1 s=1 i=0 vol=5",
               spike_valid, spike_out, spike_idx, vol_out);
    end
  endtask

  task automatic test_reuse();
    for (int i = 1; i < 40; i++) begin
      load(1'b1);
      do_export();
      checks++;
      if ({spike_valid, spike_out, spike_idx, vol_out} !== {1'b1, 1'b0, 6'(i), 16'sd63}) begin
        errors++;
        $display("FAIL walk_step1 got v=%b s=%b i=%0d vol=%0d want v=1 s=0 i=%0d vol=63",
                 spike_valid, spike_out, spike_idx, vol_out, i);
      end
    end
    w_n_a_valid = 1'b1; weight = 8'sd50; act = 1'b1;
    load(1'b1);
    beat(8'sd50, 1'b1);
    do_export();
    checks++;
    if ({spike_valid, spike_out, spike_idx, vol_out} !== {1'b1, 1'b0, 6'd0, 16'sd75}) begin
      errors++;
      $display("FAIL reuse_cur got v=%b s=%b i=%0d vol=%0d want v=1 s=0 i=0 vol=75",
               spike_valid, spike_out, spike_idx, vol_out);
    end
  endtask

  task automatic test_saturation();
    sweep(16'sd32700);
    load(1'b0);
    repeat (3) beat(8'sd127, 1'b1);
    do_export();
    checks++;
    if ({spike_valid, spike_out, spike_idx, vol_out} !== {1'b1, 1'b1, 6'd1, 16'sd32639}) begin
      errors++;
      $display("FAIL pos_sat got v=%b s=%b i=%0d vol=%0d want v=1 s=1 i=1 vol=32639",
               spike_valid, spike_out, spike_idx, vol_out);
    end
    sweep(16'sd100);
    load(1'b0);
    beat(8'sd28, 1'b1);
    do_export();
    checks++;
    if ({spike_valid, spike_out, spike_idx, vol_out} !== {1'b1, 1'b1, 6'd2, 16'sd0}) begin
      errors++;
      $display("FAIL thresh_equal got v=%b s=%b i=%0d vol=%0d want v=1 s=1 i=2 vol=0",
               spike_valid, spike_out, spike_idx, vol_out);
    end
    load(1'b0);
    beat(8'sd27, 1'b1);
    do_export();
    checks++;
    if ({spike_valid, spike_out, spike_idx, vol_out} !== {1'b1, 1'b0, 6'd3, 16'sd127}) begin
      errors++;
      $display("FAIL thresh_below got v=%b s=%b i=%0d vol=%0d want v=1 s=0 i=3 vol=127",
               spike_valid, spike_out, spike_idx, vol_out);
    end
    sweep(-16'sd32700);
    load(1'b0);
    repeat (3) beat(-8'sd128, 1'b1);
    do_export();
    checks++;
    if ({spike_valid, spike_out, spike_idx, vol_out} !== {1'b1, 1'b0, 6'd4, 16'h8000}) begin
      errors++;
      $display("FAIL neg_sat got v=%b s=%b i=%0d vol=%0d want v=1 s=0 i=4 vol=-32768",
               spike_valid, spike_out, spike_idx, vol_out);
    end
  endtask

  task automatic test_proto_err();
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL proto_clean got %b want 0", proto_err);
    end
    do_export();
    checks++;
    if ({spike_valid, proto_err} !== 2'b01) begin
      errors++;
      $display("FAIL idle_export got v=%b pe=%b want v=0 pe=1", spike_valid, proto_err);
    end
    load(1'b0);
    do_export();
    checks++;
    if ({spike_valid, spike_out, spike_idx, vol_out} !== {1'b1, 1'b0, 6'd5, -16'sd32700}) begin
      errors++;
      $display("FAIL ptr_after_err got v=%b s=%b i=%0d vol=%0d want v=1 s=0 i=5 vol=-32700",
               spike_valid, spike_out, spike_idx, vol_out);
    end
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL proto_sticky got %b want 1", proto_err);
    end
  endtask

  task automatic test_reset_mid();
    load(1'b0);
    beat(8'sd10, 1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({spike_valid, spike_out, spike_idx, vol_out, proto_err} !== 25'd0) begin
      errors++;
      $display("FAIL mid_reset got v=%b s=%b i=%0d vol=%0d pe=%b want all 0",
               spike_valid, spike_out, spike_idx, vol_out, proto_err);
    end
    step();
    rst_n = 1'b1;
    step();
    sweep(16'sd10);
    load(1'b0);
    do_export();
    checks++;
    if ({spike_valid, spike_out, spike_idx, vol_out} !== {1'b1, 1'b0, 6'd0, 16'sd10}) begin
      errors++;
      $display("FAIL post_reset_idx got v=%b s=%b i=%0d vol=%0d want v=1 s=0 i=0 vol=10",
               spike_valid, spike_out, spike_idx, vol_out);
    end
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_accum_fire();
    test_reuse();
    test_saturation();
    test_proto_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hidden_neuron_acc.md
Name: hidden_neuron_acc

Overview:
- Downstream datapath driven by controller_SM_updated: holds the membrane voltage and synaptic-current memories for the N hidden LIF neurons.
- Accumulates weight×activation into the synaptic current on time step 0, and reuses the stored current on later steps.
- On each export, performs the threshold/fire/subtractive-reset update and streams one spike result per neuron.

Parameters:
N_NEURON, 40, hidden neurons per time step; pointer wraps at N_NEURON-1
VW, 16, signed voltage/current width
WW, 8, signed weight width
THRESH, 128, firing threshold (signed VW)
LEAK_SHIFT, 4, leak shift; used only with HNA_LEAK_EN

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
vol_mem_control  in  1  init write strobe, one per neuron
init_mem_vol  in  VW  init voltage value
load_voltage  in  1  start neuron update
arithm  in  1  1 = reuse stored current (steps 1..3)
w_n_a_valid  in  1  weight/activation beat valid
weight  in  WW  signed synaptic weight
act  in  1  input spike for this beat
export_voltage  in  1  finish neuron: fire and write back
spike_valid  out  1  pulse: result for spike_idx
spike_out  out  1  neuron fired
spike_idx  out  6  neuron index of result
vol_out  out  VW  post-update voltage of spike_idx
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async, rst_n low) clears: ptr=0; state=S_IDLE; acc=0; cur_acc=0; spike_valid=0; spike_out=0; spike_idx=0; vol_out=0; proto_err=0.
- Memories vol_mem[N] and cur_mem[N] are not reset; contents are valid only after an init sweep.
- FSM states: S_IDLE, S_INIT, S_ACCUM, S_REUSE.
- Event priority per cycle: vol_mem_control > export_voltage > load_voltage > w_n_a_valid.
- vol_mem_control (any state):
  - vol_mem[ptr] <= init_mem_vol; cur_mem[ptr] <= 0.
  - ptr increments, wrapping at N_NEURON-1.
  - State goes to S_INIT; S_INIT returns to S_IDLE on the first cycle without the strobe.
- load_voltage in S_IDLE: acc <= vol_mem[ptr].
  - arithm=0: cur_acc <= 0; go to S_ACCUM.
  - arithm=1: cur_acc <= cur_mem[ptr]; go to S_REUSE. A w_n_a_valid in the same cycle is ignored.
- w_n_a_valid in S_ACCUM with act=1: cur_acc <= sat(cur_acc + sext(weight)).
  - act=0: no change.
  - w_n_a_valid is ignored in every other state.
- export_voltage in S_ACCUM or S_REUSE:
  - v = sat(acc + cur_acc).
  - fire = (v >= THRESH).
  - vol_mem[ptr] <= fire ? v-THRESH : v.
  - cur_mem[ptr] <= cur_acc only when in S_ACCUM.
  - Next cycle: spike_valid=1 for exactly one cycle; spike_idx=ptr (pre-increment); spike_out=fire; vol_out = written value.
  - ptr increments, wrapping at N_NEURON-1; state returns to S_IDLE.
- Latency: export_voltage to spike_valid is 1 cycle.
- sat(): clamp to [-2^(VW-1), 2^(VW-1)-1] on every add.
- proto_err is set (sticky until reset) by:
  - export_voltage in S_IDLE; the export is ignored.
  - load_voltage outside S_IDLE; the load is ignored.
  - export_voltage and load_voltage in the same cycle; export wins.
- Reset mid-update: the partial neuron is discarded and ptr returns to 0; a new init sweep is required.

Optional Feature:
- Macro HNA_LEAK_EN.
- Defined: at load, acc <= vol - (vol >>> LEAK_SHIFT), arithmetic shift, applied before accumulation.
- Undefined: no leak; acc <= vol exactly; LEAK_SHIFT is unused.

Decomposition:
- Shared package snn_pkg holds: VW, WW, N_NEURON, THRESH defaults; FSM state encoding; the sat() function.
- One natural sub-module, lif_fire_unit (combinational): add, saturate, threshold compare, subtractive reset.
- Memories and FSM stay in the top.

Test Plan:
- Init sweep of 40 strobes with init_mem_vol=63 → ptr wraps to 0; load then immediate export gives spike_idx=0, spike_out=0, vol_out=63.
- Step 0, neuron 0: beats weight=+40 act=1, +30 act=1, +100 act=0 → v=133, spike_out=1, vol_out=5; cur_mem[0]=70.
- Step 1 (arithm=1), neuron 0 with vol=5, stored cur=70 → v=75, no spike, vol_out=75; w_n_a_valid asserted with load is ignored.
- Saturation: vol=32700, beats +127 ×3 → v clamps to 32767, fires, vol_out=32639.
- Protocol errors: export in S_IDLE → proto_err=1, no spike_valid, ptr unchanged; further error-free traffic leaves proto_err high until reset.
- Reset mid-S_ACCUM → all outputs 0, ptr=0; after a fresh init sweep, the next export reports spike_idx=0.
